// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: o_A = A + B*W, o_B = A - B*W.
// Build option: define BUTTERFLY_SAT_EN to clamp out-of-range results instead of wrapping.
module butterfly_pipe #(
  parameter int WORD_SZ   = 32,
  parameter int WORD_MID  = WORD_SZ / 2,
  parameter int FRAC_BITS = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_SZ-1:0] i_A,
  input  logic [WORD_SZ-1:0] i_B,
  input  logic [WORD_SZ-1:0] i_twiddleA,
  input  logic               i_inverse,
  input  logic               i_scale,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_SZ-1:0] o_A,
  output logic [WORD_SZ-1:0] o_B,
  output logic               o_ovf
);
  localparam int PW = 2 * WORD_MID;
  localparam int SW = WORD_MID + 1;
  localparam int RW = WORD_MID + 2;

  // Handshake: input transfers on i_valid & o_ready, output transfers on
  // o_valid & i_ready; the whole pipe moves together whenever advance is high.
  logic advance;
  logic v1, v2;
  assign advance = i_ready | ~o_valid;
  assign o_ready = advance;

  // ---------------- S1: partial products ----------------
  logic signed [WORD_MID-1:0] b_re, b_im, w_re, w_im;
  logic signed [PW-1:0]       m_rr, m_ii, m_ri, m_ir;
  assign b_re = i_B[WORD_SZ-1 -: WORD_MID];
  assign b_im = i_B[WORD_MID-1:0];
  assign w_re = i_twiddleA[WORD_SZ-1 -: WORD_MID];
  assign w_im = i_twiddleA[WORD_MID-1:0];
  assign m_rr = PW'(b_re) * PW'(w_re);
  assign m_ii = PW'(b_im) * PW'(w_im);
  assign m_ri = PW'(b_re) * PW'(w_im);
  assign m_ir = PW'(b_im) * PW'(w_re);

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [WORD_SZ-1:0]   a1, a2;
  logic                 inv1, sc1, sc2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      a1   <= '0;
      inv1 <= 1'b0;
      sc1  <= 1'b0;
    end else if (advance) begin
      v1   <= i_valid;
      p_rr <= m_rr;
      p_ii <= m_ii;
      p_ri <= m_ri;
      p_ir <= m_ir;
      a1   <= i_A;
      inv1 <= i_inverse;
      sc1  <= i_scale;
    end
  end

  // ---------------- S2: complex product, one guard bit ----------------
  logic signed [PW:0] x_rr, x_ii, x_ri, x_ir, pr_full, pi_full, pr_sh, pi_sh;
  assign x_rr = {p_rr[PW-1], p_rr};
  assign x_ii = {p_ii[PW-1], p_ii};
  assign x_ri = {p_ri[PW-1], p_ri};
  assign x_ir = {p_ir[PW-1], p_ir};

  // Inverse mode multiplies by conj(W), flipping the sign of every Wi term.
  always_comb begin
    if (inv1) begin
      pr_full = x_rr + x_ii;
      pi_full = x_ir - x_ri;
    end else begin
      pr_full = x_rr - x_ii;
      pi_full = x_ri + x_ir;
    end
  end
  assign pr_sh = pr_full >>> FRAC_BITS;
  assign pi_sh = pi_full >>> FRAC_BITS;

  logic signed [SW-1:0] pr2, pi2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2  <= 1'b0;
      pr2 <= '0;
      pi2 <= '0;
      a2  <= '0;
      sc2 <= 1'b0;
    end else if (advance) begin
      v2  <= v1;
      pr2 <= pr_sh[SW-1:0];
      pi2 <= pi_sh[SW-1:0];
      a2  <= a1;
      sc2 <= sc1;
    end
  end

  // ---------------- S3: add/subtract, scale, range reduce ----------------
  logic signed [RW-1:0] a_re, a_im, p_re, p_im, r_ar, r_ai, r_br, r_bi;
  assign a_re = {{2{a2[WORD_SZ-1]}}, a2[WORD_SZ-1 -: WORD_MID]};
  assign a_im = {{2{a2[WORD_MID-1]}}, a2[WORD_MID-1:0]};
  assign p_re = {pr2[SW-1], pr2};
  assign p_im = {pi2[SW-1], pi2};

  always_comb begin
    r_ar = a_re + p_re;
    r_ai = a_im + p_im;
    r_br = a_re - p_re;
    r_bi = a_im - p_im;
    if (sc2) begin
      r_ar = r_ar >>> 1;
      r_ai = r_ai >>> 1;
      r_br = r_br >>> 1;
      r_bi = r_bi >>> 1;
    end
  end

  // In range exactly when the bits from the output sign bit upward all agree.
  function automatic logic out_of_range(input logic [RW-1:0] x);
    return !((&x[RW-1:WORD_MID-1]) || !(|x[RW-1:WORD_MID-1]));
  endfunction

  function automatic logic [WORD_MID-1:0] reduce(input logic [RW-1:0] x);
    logic [WORD_MID-1:0] res;
    res = x[WORD_MID-1:0];
`ifdef BUTTERFLY_SAT_EN
    if (out_of_range(x))
      res = x[RW-1] ? {1'b1, {(WORD_MID-1){1'b0}}} : {1'b0, {(WORD_MID-1){1'b1}}};
`endif
    return res;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_A     <= '0;
      o_B     <= '0;
      o_ovf   <= 1'b0;
    end else if (advance) begin
      o_valid <= v2;
      o_A     <= {reduce(r_ar), reduce(r_ai)};
      o_B     <= {reduce(r_br), reduce(r_bi)};
      o_ovf   <= out_of_range(r_ar) | out_of_range(r_ai) |
                 out_of_range(r_br) | out_of_range(r_bi);
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: vector table, random back-pressure stream, latency and mid-stream reset.
module tb_butterfly_pipe;
  localparam int W = 65;

  typedef struct {
    logic [31:0] a, b, w;
    logic        inv, sc;
    logic [31:0] ea, eb;
    logic        eo;
  } vec_t;

`ifdef BUTTERFLY_SAT_EN
  localparam logic [31:0] OVF_A = 32'h7FFF0000;
  localparam logic [31:0] MN_B  = 32'h80008000;
`else
  localparam logic [31:0] OVF_A = 32'hFE000000;
  localparam logic [31:0] MN_B  = 32'h00000000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, o_valid, i_ready, i_inverse, i_scale, o_ovf;
  logic [31:0] i_A, i_B, i_twiddleA, o_A, o_B;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  butterfly_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_A), .i_B(i_B), .i_twiddleA(i_twiddleA), .i_inverse(i_inverse),
    .i_scale(i_scale), .o_valid(o_valid), .i_ready(i_ready),
    .o_A(o_A), .o_B(o_B), .o_ovf(o_ovf)
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Independent reference: integer arithmetic on the decoded components.
  function automatic logic [W-1:0] model(input logic [31:0] a, b, w, input logic inv, sc);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    longint r[4];
    logic [15:0] q[4];
    logic ov;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    if (inv) wi = -wi;
    pr = (br * wr - bi * wi) >>> 6;
    pi = (br * wi + bi * wr) >>> 6;
    r[0] = ar + pr;
    r[1] = ai + pi;
    r[2] = ar - pr;
    r[3] = ai - pi;
    ov = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) r[k] = r[k] >>> 1;
      q[k] = 16'(r[k]);
      if (r[k] > 32767 || r[k] < -32768) begin
        ov = 1'b1;
`ifdef BUTTERFLY_SAT_EN
        q[k] = (r[k] > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
    end
    return {q[0], q[1], q[2], q[3], ov};
  endfunction

  function automatic vec_t tv(input logic [31:0] a, b, w, input logic inv, sc,
                              input logic [31:0] ea, eb, input logic eo);
    vec_t v;
    v.a = a; v.b = b; v.w = w; v.inv = inv; v.sc = sc;
    v.ea = ea; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int br, bi, wr, wi;
    br = int'($urandom_range(32767)) - 16384;
    bi = int'($urandom_range(32767)) - 16384;
    wr = int'($urandom_range(128)) - 64;
    wi = int'($urandom_range(128)) - 64;
    v.a   = $urandom();
    v.b   = {16'(br), 16'(bi)};
    v.w   = {16'(wr), 16'(wi)};
    v.inv = 1'($urandom_range(1));
    v.sc  = 1'($urandom_range(1));
    {v.ea, v.eb, v.eo} = model(v.a, v.b, v.w, v.inv, v.sc);
    return v;
  endfunction

  // Output monitor: scoreboard pops on every transfer out; stall stability checks.
  logic         stalled_prev = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h required no output", {o_A, o_B, o_ovf});
      end else begin
        check("out_pair", {o_A, o_B, o_ovf}, exp_q.pop_front());
      end
    end
    if (!rst && o_valid && !i_ready) begin
      if (stalled_prev) check("held_stable", {o_A, o_B, o_ovf}, held);
      check("ready_low_in_stall", W'(o_ready), W'(1'b0));
      held = {o_A, o_B, o_ovf};
      stalled_prev = 1'b1;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic drive(input vec_t v);
    i_A = v.a; i_B = v.b; i_twiddleA = v.w; i_inverse = v.inv; i_scale = v.sc;
    i_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int guard;
    drive(v);
    @(negedge clk);
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: o_ready=%b required 1", o_ready);
    end else begin
      exp_q.push_back({v.ea, v.eb, v.eo});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic latency_probe(input vec_t v);
    int n;
    drive(v);
    @(negedge clk);
    check("probe_ready", W'(o_ready), W'(1'b1));
    exp_q.push_back({v.ea, v.eb, v.eo});
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", W'(n), W'(3));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check("drain_left", W'(exp_q.size()), W'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[9];
    vec_t sv;
    int   base;
    int   g;

    tbl[0] = tv(32'h00400080, 32'h00C00100, 32'h00400000, 0, 0, 32'h01000180, 32'hFF80FF80, 0);
    tbl[1] = tv(32'h00400080, 32'h00C00100, 32'h0000FFC0, 0, 0, 32'h0140FFC0, 32'hFF400140, 0);
    tbl[2] = tv(32'h00400080, 32'h00C00100, 32'h00000040, 1, 0, 32'h0140FFC0, 32'hFF400140, 0);
    tbl[3] = tv(32'h00400080, 32'h00C00100, 32'h00400000, 0, 1, 32'h008000C0, 32'hFFC0FFC0, 0);
    tbl[4] = tv(32'h7F000000, 32'h7F000000, 32'h00400000, 0, 0, OVF_A,        32'h00000000, 1);
    tbl[5] = tv(32'h00400080, 32'h00C00100, 32'hFFC00000, 0, 0, 32'hFF80FF80, 32'h01000180, 0);
    tbl[6] = tv(32'h80008000, 32'h80008000, 32'hFFC00000, 0, 0, 32'h00000000, MN_B,         1);
    tbl[7] = tv(32'h00000000, 32'hFFFF0000, 32'h00200000, 0, 0, 32'hFFFF0000, 32'h00010000, 0);
    tbl[8] = tv(32'h0003FFFD, 32'h00000000, 32'h00000000, 0, 1, 32'h0001FFFE, 32'h0001FFFE, 0);

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_A = '0; i_B = '0; i_twiddleA = '0; i_inverse = 1'b0; i_scale = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", W'(o_valid), W'(1'b0));
    check("rst_o_ovf",   W'(o_ovf),   W'(1'b0));
    check("rst_o_A",     W'(o_A),     W'(0));
    check("rst_o_B",     W'(o_B),     W'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", W'(o_ready), W'(1'b1));
    @(posedge clk); #1;

    // Latency of a lone sample, then the table streamed back to back
    latency_probe(tbl[0]);
    wait_drain();
    for (int i = 0; i < 9; i++) send(tbl[i]);
    wait_drain();

    // Back-pressure: 8 random vectors, i_ready low for 5 cycles while o_valid
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          sv = rand_vec();
          send(sv);
        end
      end
      begin
        g = 0;
        while (!o_valid && g < 50) begin
          @(posedge clk); #1;
          g++;
        end
        check("bp_saw_valid", W'(o_valid), W'(1'b1));
        i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_count", W'(n_out - base), W'(8));

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      sv = rand_vec();
      send(sv);
    end
    check("inflight_valid", W'(o_valid), W'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", W'(o_valid), W'(1'b0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", W'(o_valid), W'(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", W'(o_valid), W'(1'b0));
    end
    @(posedge clk); #1;
    latency_probe(tbl[1]);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
